// File: rtl/audio_frame_sequencer.sv
// Frame sequencer between the codec read/write handshake and the stereo
// moving-average datapath. Every output is a register loaded from the *_nxt
// values computed by the FSM process, so each strobe is high during exactly
// the state it belongs to (read/dp_valid in ISSUE, dp_flush in FLUSH, write
// in the IDLE cycle that follows WAIT_WR).
module audio_frame_sequencer #(
    parameter int MAX_LOG2N     = 6,
    parameter int DEFAULT_LOG2N = 6,
    parameter int TIMEOUT       = 64
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        read_ready,
    input  logic        write_ready,
    input  logic [23:0] readdata_left,
    input  logic [23:0] readdata_right,
    output logic        read,
    output logic        write,
    output logic [23:0] writedata_left,
    output logic [23:0] writedata_right,
    input  logic [2:0]  cfg_log2n,
    output logic        dp_valid,
    output logic        dp_push,
    output logic        dp_pop,
    output logic        dp_flush,
    output logic [23:0] dp_left,
    output logic [23:0] dp_right,
    input  logic        dp_done,
    input  logic [23:0] dp_res_left,
    input  logic [23:0] dp_res_right,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] frame_cnt
);
    // fill_cnt must be able to hold the full window 2**MAX_LOG2N
    localparam int FW = MAX_LOG2N + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]    MAX_L     = 3'(MAX_LOG2N);
    localparam logic [2:0]    DEF_L     = 3'(DEFAULT_LOG2N);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        ISSUE,
        WAIT_DP,
        WAIT_WR
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    active_log2n, active_nxt;
    logic [FW-1:0] fill_cnt, fill_nxt;
    logic [TW-1:0] wait_cnt, wait_nxt;

    logic          read_nxt, write_nxt, valid_nxt, push_nxt, pop_nxt, flush_nxt;
    logic          busy_nxt, terr_nxt;
    logic [23:0]   dp_left_nxt, dp_right_nxt, wd_left_nxt, wd_right_nxt;
    logic [15:0]   frame_nxt;

    logic [2:0]    cfg_clamped;
    logic [FW-1:0] window;

    assign cfg_clamped = (cfg_log2n > MAX_L) ? MAX_L : cfg_log2n;
    assign window      = FW'(1) << active_log2n;

    // state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state plus the next value of every registered output and counter
    always_comb begin
        state_nxt    = state;
        active_nxt   = active_log2n;
        fill_nxt     = fill_cnt;
        wait_nxt     = wait_cnt;
        dp_left_nxt  = dp_left;
        dp_right_nxt = dp_right;
        wd_left_nxt  = writedata_left;
        wd_right_nxt = writedata_right;
        terr_nxt     = timeout_err;
        frame_nxt    = frame_cnt;
        read_nxt     = 1'b0;
        write_nxt    = 1'b0;
        valid_nxt    = 1'b0;
        push_nxt     = 1'b0;
        pop_nxt      = 1'b0;
        flush_nxt    = 1'b0;

        case (state)
            IDLE: begin
                // a window change wins over a pending sample so the new
                // window never mixes with samples from the old one
                if (cfg_clamped != active_log2n) begin
                    active_nxt = cfg_clamped;
                    fill_nxt   = '0;
                    flush_nxt  = 1'b1;
                    state_nxt  = FLUSH;
                end else if (read_ready) begin
                    dp_left_nxt  = readdata_left;
                    dp_right_nxt = readdata_right;
                    read_nxt     = 1'b1;
                    valid_nxt    = 1'b1;
                    push_nxt     = 1'b1;
                    pop_nxt      = (fill_cnt == window);
                    state_nxt    = ISSUE;
                end
            end
            FLUSH: state_nxt = IDLE;
            ISSUE: begin
                // priming: count pushes until the window is full, then hold
                if (fill_cnt < window) fill_nxt = fill_cnt + FW'(1);
                wait_nxt  = '0;
                state_nxt = WAIT_DP;
            end
            WAIT_DP: begin
                if (dp_done) begin
                    wd_left_nxt  = dp_res_left;
                    wd_right_nxt = dp_res_right;
                    state_nxt    = WAIT_WR;
                end else if (wait_cnt == WAIT_LAST) begin
                    // abandon the frame but still hand the codec a sample
                    wd_left_nxt  = '0;
                    wd_right_nxt = '0;
                    terr_nxt     = 1'b1;
                    state_nxt    = WAIT_WR;
                end else begin
                    wait_nxt = wait_cnt + TW'(1);
                end
            end
            WAIT_WR: begin
                if (write_ready) begin
                    write_nxt = 1'b1;
                    frame_nxt = frame_cnt + 16'd1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // counters and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            active_log2n    <= DEF_L;
            fill_cnt        <= '0;
            wait_cnt        <= '0;
            read            <= 1'b0;
            write           <= 1'b0;
            dp_valid        <= 1'b0;
            dp_push         <= 1'b0;
            dp_pop          <= 1'b0;
            dp_flush        <= 1'b0;
            dp_left         <= '0;
            dp_right        <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            frame_cnt       <= '0;
        end else begin
            active_log2n    <= active_nxt;
            fill_cnt        <= fill_nxt;
            wait_cnt        <= wait_nxt;
            read            <= read_nxt;
            write           <= write_nxt;
            dp_valid        <= valid_nxt;
            dp_push         <= push_nxt;
            dp_pop          <= pop_nxt;
            dp_flush        <= flush_nxt;
            dp_left         <= dp_left_nxt;
            dp_right        <= dp_right_nxt;
            writedata_left  <= wd_left_nxt;
            writedata_right <= wd_right_nxt;
            busy            <= busy_nxt;
            timeout_err     <= terr_nxt;
            frame_cnt       <= frame_nxt;
        end
    end
endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Bench for audio_frame_sequencer: plays codec and datapath, predicts each
// frame from a frame-level model (window priming, flushes, timeouts, counts).
module tb_audio_frame_sequencer;
    localparam int TIMEOUT = 64;
    localparam int MAXL    = 6;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        read_ready = 1'b0, write_ready = 1'b0;
    logic [23:0] readdata_left = '0, readdata_right = '0;
    logic        read, write;
    logic [23:0] writedata_left, writedata_right;
    logic [2:0]  cfg_log2n = 3'd6;
    logic        dp_valid, dp_push, dp_pop, dp_flush;
    logic [23:0] dp_left, dp_right;
    logic        dp_done = 1'b0;
    logic [23:0] dp_res_left = '0, dp_res_right = '0;
    logic        busy, timeout_err;
    logic [15:0] frame_cnt;

    always #5 CLOCK_50 = ~CLOCK_50;

    audio_frame_sequencer #(.MAX_LOG2N(MAXL), .DEFAULT_LOG2N(6), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .read_ready(read_ready), .write_ready(write_ready),
        .readdata_left(readdata_left), .readdata_right(readdata_right),
        .read(read), .write(write),
        .writedata_left(writedata_left), .writedata_right(writedata_right),
        .cfg_log2n(cfg_log2n),
        .dp_valid(dp_valid), .dp_push(dp_push), .dp_pop(dp_pop), .dp_flush(dp_flush),
        .dp_left(dp_left), .dp_right(dp_right),
        .dp_done(dp_done), .dp_res_left(dp_res_left), .dp_res_right(dp_res_right),
        .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    int checks = 0, errors = 0;
    int n_read = 0, n_write = 0, n_flush = 0, n_overlap = 0, cyc = 0;

    // strobe counters, sampled mid-cycle
    always @(negedge CLOCK_50) begin
        if (read)          n_read    <= n_read + 1;
        if (write)         n_write   <= n_write + 1;
        if (dp_flush)      n_flush   <= n_flush + 1;
        if (read && write) n_overlap <= n_overlap + 1;
    end

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // frame-level reference state
    int          m_active = 6, m_fill = 0, m_flush = 0, m_frames = 0;
    logic        m_terr = 1'b0;
    logic [23:0] m_prev_l = '0, m_prev_r = '0;

    function automatic int clampf(input int c);
        return (c > MAXL) ? MAXL : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_strobes"}, 32'({read, write, dp_valid, dp_push, dp_pop, dp_flush, busy, timeout_err}), 32'd0);
        chk({pfx, "_dp_data"}, 32'(dp_left | dp_right), 32'd0);
        chk({pfx, "_wr_data"}, 32'(writedata_left | writedata_right), 32'd0);
        chk({pfx, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    // One frame. lat>0: dp_done lat cycles after dp_valid; lat<=0: never.
    // wr_delay==0: write_ready high throughout; else held low that long
    // after the result, with a stray dp_done that must be ignored.
    task automatic run_frame(input logic [23:0] l, input logic [23:0] r, input int lat,
                             input logic [23:0] rl, input logic [23:0] rr,
                             input int wr_delay, input int cfg_mid, input bit hold_rr);
        int          rd0, t0, win;
        bit          got;
        logic [23:0] el, er;
        if (clampf(int'(cfg_log2n)) != m_active) begin
            m_active = clampf(int'(cfg_log2n));
            m_fill   = 0;
            m_flush++;
        end
        win = 1 << m_active;
        rd0 = n_read;
        readdata_left = l; readdata_right = r;
        read_ready = 1'b1;
        write_ready = (wr_delay == 0);
        got = 0;
        for (int n = 0; n < 12 && !got; n++) begin
            step();
            if (dp_valid) got = 1;
        end
        t0 = cyc;
        chk("dp_valid_seen", 32'(got), 32'd1);
        if (!hold_rr) read_ready = 1'b0;
        chk("dp_push", 32'(dp_push), 32'd1);
        chk("dp_pop", 32'(dp_pop), 32'(m_fill >= win));
        chk("dp_left", 32'(dp_left), 32'(l));
        chk("dp_right", 32'(dp_right), 32'(r));
        chk("flush_cnt", 32'(n_flush), 32'(m_flush));
        chk("busy", 32'(busy), 32'd1);
        chk("wd_held_l", 32'(writedata_left), 32'(m_prev_l));
        chk("wd_held_r", 32'(writedata_right), 32'(m_prev_r));
        if (m_fill < win) m_fill++;
        if (cfg_mid >= 0) cfg_log2n = 3'(cfg_mid);

        if (lat > 0) begin
            el = rl; er = rr;
            repeat (lat) step();
            dp_done = 1'b1; dp_res_left = rl; dp_res_right = rr;
            step();
            dp_done = 1'b0;
        end else begin
            el = '0; er = '0;
            m_terr = 1'b1;
            if (wr_delay > 0) repeat (TIMEOUT + 1) step();
        end
        if (wr_delay > 0) begin
            dp_done = 1'b1; dp_res_left = ~rl; dp_res_right = ~rr;
            step();
            dp_done = 1'b0;
            repeat (wr_delay - 1) step();
            chk("no_early_write_read", 32'(n_read - rd0), 32'd1);
            write_ready = 1'b1;
        end

        got = 0;
        for (int n = 0; n < TIMEOUT + 20 && !got; n++) begin
            if (write) got = 1;
            else step();
        end
        write_ready = 1'b0;
        if (hold_rr) read_ready = 1'b0;
        m_frames++;
        chk("write_seen", 32'(got), 32'd1);
        chk("writedata_left", 32'(writedata_left), 32'(el));
        chk("writedata_right", 32'(writedata_right), 32'(er));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames % 65536));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("busy_idle", 32'(busy), 32'd0);
        if (wr_delay == 0) chk("latency", 32'(cyc - t0), 32'((lat > 0) ? lat + 2 : TIMEOUT + 2));
        step();
        chk("reads_per_frame", 32'(n_read - rd0), 32'd1);
        m_prev_l = el; m_prev_r = er;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        bit got;
        repeat (3) step();
        check_zero("reset_hold");
        reset = 1'b0;
        step();
        check_zero("reset_idle");

        // basic frame with signed data, no flush at the default window
        run_frame(24'h000100, 24'hFFFF00, 3, 24'h000005, 24'hFFFFFB, 0, -1, 0);

        // window of 4: flush first, pop only once primed
        cfg_log2n = 3'd2;
        for (int f = 0; f < 6; f++)
            run_frame(24'(f + 1), 24'(-(f + 1)), f + 1, 24'(f * 7), 24'(f * 11), f % 3, -1, 0);

        // window change during WAIT_DP takes effect after the frame completes
        run_frame(24'h0A0A0A, 24'h0B0B0B, 2, 24'h111111, 24'h222222, 1, 3, 0);
        run_frame(24'h0C0C0C, 24'h0D0D0D, 1, 24'h333333, 24'h444444, 0, -1, 0);

        // datapath never answers, then the sticky error survives good frames
        run_frame(24'h123456, 24'h654321, 0, 24'h0, 24'h0, 0, -1, 0);
        run_frame(24'h777777, 24'h888888, 0, 24'h0, 24'h0, 3, -1, 0);
        run_frame(24'h999999, 24'hAAAAAA, 4, 24'hBBBBBB, 24'hCCCCCC, 0, -1, 0);

        // stalled codec output with input always ready
        run_frame(24'h010203, 24'h040506, 2, 24'h0F0F0F, 24'hF0F0F0, 100, -1, 1);

        // random traffic including window changes and clamping
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(3) == 0) cfg_log2n = 3'($urandom_range(7));
            run_frame(24'($urandom), 24'($urandom), int'($urandom_range(12, 1)),
                      24'($urandom), 24'($urandom), int'($urandom_range(6)), -1, 0);
        end

        // reset while waiting for the codec to accept the result
        read_ready = 1'b1; write_ready = 1'b0;
        got = 0;
        for (int n = 0; n < 12 && !got; n++) begin
            step();
            if (dp_valid) got = 1;
        end
        chk("rst_dp_valid_seen", 32'(got), 32'd1);
        read_ready = 1'b0;
        step();
        dp_done = 1'b1; dp_res_left = 24'h123456; dp_res_right = 24'h654321;
        step();
        dp_done = 1'b0;
        chk("rst_busy_pre", 32'(busy), 32'd1);
        wr0 = n_write;
        write_ready = 1'b1;
        reset = 1'b1;
        step();
        check_zero("mid_reset");
        reset = 1'b0;
        step();
        check_zero("post_reset");
        step();
        chk("rst_no_write", 32'(n_write - wr0), 32'd0);
        write_ready = 1'b0;
        m_active = 6; m_fill = 0; m_frames = 0; m_terr = 1'b0;
        m_prev_l = '0; m_prev_r = '0;

        // 7 clamps to the default 6: no flush, window restarts empty
        cfg_log2n = 3'd7;
        run_frame(24'h00ABCD, 24'hFFDCBA, 2, 24'h000042, 24'hFFFFBE, 0, -1, 0);
        chk("no_overlap", 32'(n_overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
